jt12_sh_wr: RTL and testbench

Circulating per-slot register store for the time-multiplexed FM pipeline. It holds `stages` slot values of `width` bits in a recirculating ring and presents the current slot's value on every clk_en cycle. It accepts host-side writes and reads for any slot, and waits for that slot to come round before committing or capturing. It is the writer/reader end that feeds the fixed-delay shift-register pipelines.

---
 rtl/jt12_sh_wr.sv | 93 +++++++++
 tb/tb_jt12_sh_wr.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/jt12_sh_wr.sv
// Recirculating per-slot register ring for the time-multiplexed FM pipeline.
// Host writes/reads wait for their slot to reach the head before committing or capturing.
module jt12_sh_wr #(
  parameter int   width  = 5,
  parameter int   stages = 24,
  parameter logic rstval = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  output logic [4:0]       cur_slot,
  output logic             zero,
  output logic [width-1:0] dout,
  input  logic             wr_req,
  input  logic [4:0]       wr_slot,
  input  logic [width-1:0] wr_data,
  output logic             busy,
  output logic             wr_ack,
  output logic             wr_err,
  input  logic             rd_req,
  input  logic [4:0]       rd_slot,
  output logic [width-1:0] rd_data,
  output logic             rd_valid
);

  localparam logic [4:0] LAST  = 5'(stages - 1);
  localparam logic [5:0] NSLOT = 6'(stages);

  logic [width-1:0] ring [stages];
  logic [4:0]       pend_slot;
  logic [width-1:0] pend_data;
  logic             rd_busy;
  logic [4:0]       rd_pend;
  logic             commit;
  logic             capture;

  assign commit  = clk_en && busy && (cur_slot == pend_slot);
  assign capture = clk_en && rd_busy && (cur_slot == rd_pend);
  assign dout    = ring[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < stages; i++) ring[i] <= {width{rstval}};
      cur_slot  <= '0;
      zero      <= 1'b1;
      busy      <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      pend_slot <= '0;
      pend_data <= '0;
      rd_busy   <= 1'b0;
      rd_pend   <= '0;
      rd_data   <= {width{rstval}};
      rd_valid  <= 1'b0;
    end else begin
      wr_ack   <= commit;
      wr_err   <= 1'b0;
      rd_valid <= 1'b0;

      if (clk_en) begin
        for (int i = 0; i < stages - 1; i++) ring[i] <= ring[i+1];
        ring[stages-1] <= commit ? pend_data : ring[0];
        cur_slot       <= (cur_slot == LAST) ? 5'd0 : cur_slot + 5'd1;
        zero           <= (cur_slot == LAST);
      end

      // Holding off while ack/err is still visible stops a requester that has
      // not yet dropped wr_req from being accepted a second time.
      if (commit) begin
        busy <= 1'b0;
      end else if (wr_req && !busy && !wr_ack && !wr_err) begin
        if ({1'b0, wr_slot} < NSLOT) begin
          pend_slot <= wr_slot;
          pend_data <= wr_data;
          busy      <= 1'b1;
        end else begin
          wr_err <= 1'b1;
        end
      end

      // Capture takes the head before any same-edge commit, so it sees the old value.
      if (capture) begin
        rd_data  <= ring[0];
        rd_valid <= 1'b1;
        rd_busy  <= 1'b0;
      end else if (rd_req && !rd_busy && !rd_valid && ({1'b0, rd_slot} < NSLOT)) begin
        rd_pend <= rd_slot;
        rd_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt12_sh_wr.sv
// Randomised and directed bench for jt12_sh_wr against a slot-indexed memory model.
module tb_jt12_sh_wr;

  localparam int STAGES = 24;
  localparam int W      = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clk_en = 1'b0;
  logic [4:0]   cur_slot;
  logic         zero;
  logic [W-1:0] dout;
  logic         wr_req = 1'b0;
  logic [4:0]   wr_slot = '0;
  logic [W-1:0] wr_data = '0;
  logic         busy, wr_ack, wr_err;
  logic         rd_req = 1'b0;
  logic [4:0]   rd_slot = '0;
  logic [W-1:0] rd_data;
  logic         rd_valid;

  int total = 0;
  int bad   = 0;

  jt12_sh_wr #(.width(W), .stages(STAGES), .rstval(1'b0)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .cur_slot(cur_slot), .zero(zero), .dout(dout),
    .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data),
    .busy(busy), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_req(rd_req), .rd_slot(rd_slot), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one value per slot plus a rotating pointer.
  int           m_slot;
  logic [W-1:0] mem [STAGES];
  bit           m_busy, m_ack, m_err, m_rbusy, m_rvalid;
  int           m_pslot, m_rslot;
  logic [W-1:0] m_pdata, m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slot = 0;
      foreach (mem[i]) mem[i] = '0;
      m_busy = 0; m_ack = 0; m_err = 0; m_rbusy = 0; m_rvalid = 0;
      m_pslot = 0; m_rslot = 0; m_pdata = '0; m_rdata = '0;
    end else begin
      bit ob, orb, n_ack, n_err, n_rv, clr_b, clr_rb;
      ob = m_busy; orb = m_rbusy;
      n_ack = 0; n_err = 0; n_rv = 0; clr_b = 0; clr_rb = 0;
      if (clk_en) begin
        if (orb && m_rslot == m_slot) begin
          m_rdata = mem[m_slot]; n_rv = 1; clr_rb = 1;
        end
        if (ob && m_pslot == m_slot) begin
          mem[m_slot] = m_pdata; n_ack = 1; clr_b = 1;
        end
        m_slot = (m_slot + 1) % STAGES;
      end
      if (clr_b) m_busy = 0;
      else if (wr_req && !ob && !m_ack && !m_err) begin
        if (int'(wr_slot) < STAGES) begin
          m_pslot = int'(wr_slot); m_pdata = wr_data; m_busy = 1;
        end else n_err = 1;
      end
      if (clr_rb) m_rbusy = 0;
      else if (rd_req && !orb && !m_rvalid && int'(rd_slot) < STAGES) begin
        m_rslot = int'(rd_slot); m_rbusy = 1;
      end
      m_ack = n_ack; m_err = n_err; m_rvalid = n_rv;
    end
  end

  always @(negedge clk) begin
    checkOutput("cur_slot", 32'(cur_slot), 32'(m_slot));
    checkOutput("zero",     32'(zero),     32'(m_slot == 0));
    checkOutput("dout",     32'(dout),     32'(mem[m_slot]));
    checkOutput("busy",     32'(busy),     32'(m_busy));
    checkOutput("wr_ack",   32'(wr_ack),   32'(m_ack));
    checkOutput("wr_err",   32'(wr_err),   32'(m_err));
    checkOutput("rd_valid", 32'(rd_valid), 32'(m_rvalid));
    checkOutput("rd_data",  32'(rd_data),  32'(m_rdata));
  end

  task automatic wait_slot(input int s);
    int n = 0;
    while (m_slot != s && n < 4 * STAGES) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_slot", 32'(m_slot), 32'(s));
  endtask

  // Raise a write and hold it until ack/err; en_mode 1 runs clk_en one-in-three.
  task automatic applyStimulus(input logic [4:0] s, input logic [W-1:0] d, input int en_mode);
    int  n = 0;
    bit  done = 0;
    wr_req = 1'b1; wr_slot = s; wr_data = d;
    while (!done && n < 4 * STAGES + 10) begin
      if (en_mode == 1) clk_en = (n % 3 == 0);
      @(negedge clk);
      n++;
      if (wr_ack || wr_err) done = 1;
    end
    wr_req = 1'b0;
    clk_en = 1'b1;
    checkOutput("handshake_seen", 32'(done), 32'd1);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit got;
    int n;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    clk_en = 1'b1;
    run(48);

    wait_slot(3);
    applyStimulus(5'd5, 5'h1A, 0);
    wait_slot(5);
    checkOutput("slot5_value", 32'(dout), 32'h1A);

    rd_req = 1'b1; rd_slot = 5'd5;
    got = 0; n = 0;
    while (!got && n < 3 * STAGES) begin
      @(negedge clk);
      n++;
      if (rd_valid) begin
        got = 1;
        checkOutput("readback_5", 32'(rd_data), 32'h1A);
      end
    end
    rd_req = 1'b0;
    checkOutput("rd_valid_seen", 32'(got), 32'd1);

    wait_slot(6);
    applyStimulus(5'd7, 5'h0F, 0);
    wait_slot(7);
    run(STAGES);
    checkOutput("slot7_value", 32'(dout), 32'h0F);

    applyStimulus(5'd30, 5'h03, 0);

    wait_slot(12);
    wr_req = 1'b1; wr_slot = 5'd9; wr_data = 5'h03;
    run(2);
    wr_slot = 5'd14; wr_data = 5'h11;
    applyStimulus(5'd14, 5'h11, 0);
    run(2 * STAGES);

    wait_slot(4);
    applyStimulus(5'd2, 5'h15, 1);
    run(STAGES + 2);

    wait_slot(11);
    wr_req = 1'b1; wr_slot = 5'd10; wr_data = 5'h1F;
    run(2);
    wr_req = 1'b0;
    #2 rst = 1'b1;
    #1 checkOutput("busy_async_clear", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_slot(10);
    checkOutput("slot10_reset", 32'(dout), 32'h0);

    repeat (3000) begin
      @(negedge clk);
      clk_en  = ($urandom_range(9) < 7);
      wr_req  = ($urandom_range(3) == 0);
      wr_slot = 5'($urandom_range(31));
      wr_data = W'($urandom);
      rd_req  = ($urandom_range(3) == 0);
      rd_slot = 5'($urandom_range(31));
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
